envelope_generator: RTL and testbench

ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

---
 rtl/envelope_generator.sv | 180 ++++++++++++++++++
 tb/tb_envelope_generator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_generator.sv
// envelope_generator: multi-voice ADSR envelope generator.
//
// A free-running divider produces one update tick every DIV clocks
// (DIV = CLOCK_FREQUENCY / UPDATE_FREQUENCY). On each tick, every voice
// advances its own ADSR state machine, stepping its level by the shared
// attack/decay/release rates toward the shared sustain target.
//
// Ports:
//   clock        system clock, rising edge
//   reset_l      asynchronous active-low reset
//   gate         per-voice note-held level
//   attack       attack rate 0..127 (0 = instant)
//   decay        decay rate 0..127 (0 = instant)
//   release_rate release rate 0..127 (0 = instant)
//   sustain      sustain level in percent (values above 100 act as 100)
//   level        per-voice registered envelope level
//   active       per-voice flag, high while the voice is not idle
//   level_valid  one-cycle pulse in the cycle after the levels update
module envelope_generator #(
  parameter int unsigned VOICE_COUNT      = 4,
  parameter int unsigned LEVEL_WIDTH      = 16,
  parameter int unsigned CLOCK_FREQUENCY  = 50000000,
  parameter int unsigned UPDATE_FREQUENCY = 50000,
  parameter int unsigned STEP_SCALE       = 1
) (
  input  logic                                   clock,
  input  logic                                   reset_l,
  input  logic [VOICE_COUNT-1:0]                 gate,
  input  logic [6:0]                             attack,
  input  logic [6:0]                             decay,
  input  logic [6:0]                             release_rate,
  input  logic [6:0]                             sustain,
  output logic [VOICE_COUNT-1:0][LEVEL_WIDTH-1:0] level,
  output logic [VOICE_COUNT-1:0]                 active,
  output logic                                   level_valid
);

  localparam int unsigned DIV   = CLOCK_FREQUENCY / UPDATE_FREQUENCY;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW    = LEVEL_WIDTH + 1;

  localparam logic [AW-1:0] CEILING  = AW'((64'd1 << LEVEL_WIDTH) - 64'd1);
  localparam logic [AW-1:0] CEIL_PCT = CEILING / AW'(100);

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_e;

  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   tick;
  logic                                   valid_q, valid_d;
  logic                                   armed_q, armed_d;
  logic [VOICE_COUNT-1:0]                 gate_prev_q, gate_prev_d;
  logic [VOICE_COUNT-1:0]                 retrig_q, retrig_d;
  state_e                                 state_q [VOICE_COUNT];
  state_e                                 state_d [VOICE_COUNT];
  logic [VOICE_COUNT-1:0][LEVEL_WIDTH-1:0] level_q, level_d;
  logic [AW-1:0]                          step_atk, step_dec, step_rel, sus_tgt;

  // Rate 0 means "complete the stage in one tick".
  function automatic logic [AW-1:0] step_of(input logic [6:0] r);
    logic [63:0] prod;
    prod = 64'(r) * 64'(STEP_SCALE);
    if ((r == '0) || (prod >= 64'(CEILING))) return CEILING;
    return AW'(prod);
  endfunction

  always_comb begin
    logic [AW-1:0] cur;
    logic [AW-1:0] sum;
    logic          rise;
    logic          climb;
    cur   = '0;
    sum   = '0;
    rise  = 1'b0;
    climb = 1'b0;

    tick        = (cnt_q == CNT_W'(DIV - 1));
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    valid_d     = tick;
    armed_d     = 1'b1;
    gate_prev_d = gate;

    step_atk = step_of(attack);
    step_dec = step_of(decay);
    step_rel = step_of(release_rate);
    // sustain < 100 keeps the product below CEILING, so AW bits suffice.
    sus_tgt  = (sustain >= 7'd100) ? CEILING : AW'(sustain) * CEIL_PCT;

    retrig_d = retrig_q;
    level_d  = level_q;
    for (int unsigned v = 0; v < VOICE_COUNT; v++) begin
      // armed_q masks the first clock after reset so a gate held through
      // reset is not seen as a rising edge.
      rise        = armed_q & gate[v] & ~gate_prev_q[v];
      cur         = {1'b0, level_q[v]};
      sum         = cur + step_atk;
      climb       = 1'b0;
      state_d[v]  = state_q[v];
      retrig_d[v] = retrig_q[v] | rise;

      if (tick) begin
        // A retrigger starts the attack from the current level and applies
        // the first attack step on the same tick.
        if (retrig_q[v] | rise) begin
          retrig_d[v] = 1'b0;
          climb       = 1'b1;
        end else if (!gate[v] && ((state_q[v] == ATTACK) || (state_q[v] == DECAY) ||
                                  (state_q[v] == SUSTAIN))) begin
          state_d[v] = RELEASE;
        end else begin
          unique case (state_q[v])
            ATTACK:  climb = 1'b1;
            DECAY: begin
              if (cur > sus_tgt + step_dec) begin
                level_d[v] = LEVEL_WIDTH'(cur - step_dec);
              end else begin
                level_d[v] = LEVEL_WIDTH'(sus_tgt);
                state_d[v] = SUSTAIN;
              end
            end
            SUSTAIN: level_d[v] = LEVEL_WIDTH'(sus_tgt);
            RELEASE: begin
              if (cur > step_rel) begin
                level_d[v] = LEVEL_WIDTH'(cur - step_rel);
              end else begin
                level_d[v] = '0;
                state_d[v] = IDLE;
              end
            end
            default: level_d[v] = '0;
          endcase
        end

        if (climb) begin
          if (sum >= CEILING) begin
            level_d[v] = LEVEL_WIDTH'(CEILING);
            state_d[v] = DECAY;
          end else begin
            level_d[v] = LEVEL_WIDTH'(sum);
            state_d[v] = ATTACK;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
      gate_prev_q <= '0;
      retrig_q    <= '0;
      level_q     <= '0;
      for (int unsigned v = 0; v < VOICE_COUNT; v++) state_q[v] <= IDLE;
    end else begin
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      armed_q     <= armed_d;
      gate_prev_q <= gate_prev_d;
      retrig_q    <= retrig_d;
      level_q     <= level_d;
      for (int unsigned v = 0; v < VOICE_COUNT; v++) state_q[v] <= state_d[v];
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned v = 0; v < VOICE_COUNT; v++) active[v] = (state_q[v] != IDLE);
  end

  assign level       = level_q;
  assign level_valid = valid_q;

endmodule

// File: tb/tb_envelope_generator.sv
// tb_envelope_generator: self-checking bench for envelope_generator.
// A behavioural model (integer min/max arithmetic, named stages) is stepped
// alongside the DUT every clock; directed scenarios add fixed-value checks.
module tb_envelope_generator;

  localparam int unsigned VC     = 4;
  localparam int unsigned LW     = 16;
  localparam int unsigned CLK_HZ = 8;
  localparam int unsigned UPD_HZ = 2;
  localparam int unsigned SCALE  = 1;
  localparam int          DIV    = CLK_HZ / UPD_HZ;
  localparam int          CEIL   = (1 << LW) - 1;

  logic                   clock   = 1'b0;
  logic                   reset_l = 1'b0;
  logic [VC-1:0]          gate    = '0;
  logic [6:0]             attack  = '0;
  logic [6:0]             decay   = '0;
  logic [6:0]             release_rate = '0;
  logic [6:0]             sustain = '0;
  logic [VC-1:0][LW-1:0]  level;
  logic [VC-1:0]          active;
  logic                   level_valid;

  int n_checks = 0;
  int n_pass   = 0;

  int    m_lvl    [VC];
  string m_stage  [VC];
  bit    m_retrig [VC];
  bit    m_prev   [VC];
  bit    m_armed;
  int    m_cnt;
  bit    m_valid;

  envelope_generator #(
    .VOICE_COUNT      (VC),
    .LEVEL_WIDTH      (LW),
    .CLOCK_FREQUENCY  (CLK_HZ),
    .UPDATE_FREQUENCY (UPD_HZ),
    .STEP_SCALE       (SCALE)
  ) dut (
    .clock        (clock),
    .reset_l      (reset_l),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .release_rate (release_rate),
    .sustain      (sustain),
    .level        (level),
    .active       (active),
    .level_valid  (level_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int step_of(input int r);
    if (r == 0) return CEIL;
    return (r * SCALE < CEIL) ? r * SCALE : CEIL;
  endfunction

  function automatic int sus_of(input int s);
    return (s >= 100) ? CEIL : s * (CEIL / 100);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
  endtask

  task automatic model_reset();
    for (int v = 0; v < VC; v++) begin
      m_lvl[v] = 0; m_stage[v] = "IDLE"; m_retrig[v] = 0; m_prev[v] = 0;
    end
    m_armed = 0; m_cnt = 0; m_valid = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit tick, rise, hold;
    int sa, sd, sr, s;
    tick = (m_cnt == DIV - 1);
    sa = step_of(int'(attack)); sd = step_of(int'(decay));
    sr = step_of(int'(release_rate)); s = sus_of(int'(sustain));
    for (int v = 0; v < VC; v++) begin
      rise = m_armed && gate[v] && !m_prev[v];
      if (!tick) begin
        if (rise) m_retrig[v] = 1;
      end else begin
        hold = 0;
        if (m_retrig[v] || rise) begin
          m_retrig[v] = 0;
          m_stage[v]  = "ATTACK";
        end else if (!gate[v] && m_stage[v] != "IDLE" && m_stage[v] != "RELEASE") begin
          m_stage[v] = "RELEASE";
          hold = 1;
        end
        if (!hold) begin
          if (m_stage[v] == "ATTACK") begin
            m_lvl[v] = imin(m_lvl[v] + sa, CEIL);
            if (m_lvl[v] == CEIL) m_stage[v] = "DECAY";
          end else if (m_stage[v] == "DECAY") begin
            m_lvl[v] = imax(m_lvl[v] - sd, s);
            if (m_lvl[v] == s) m_stage[v] = "SUSTAIN";
          end else if (m_stage[v] == "SUSTAIN") begin
            m_lvl[v] = s;
          end else if (m_stage[v] == "RELEASE") begin
            m_lvl[v] = imax(m_lvl[v] - sr, 0);
            if (m_lvl[v] == 0) m_stage[v] = "IDLE";
          end else begin
            m_lvl[v] = 0;
          end
        end
      end
      m_prev[v] = gate[v];
    end
    m_armed = 1;
    m_cnt   = tick ? 0 : m_cnt + 1;
    m_valid = tick;
  endtask

  task automatic check_outputs();
    chk("level_valid", 32'(level_valid), 32'(m_valid));
    for (int v = 0; v < VC; v++) begin
      chk($sformatf("level[%0d]", v), 32'(level[v]), 32'(m_lvl[v]));
      chk($sformatf("active[%0d]", v), 32'(active[v]), 32'(m_stage[v] != "IDLE"));
    end
  endtask

  task automatic cycle();
    if (reset_l) model_edge();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic run_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      cycle();
      if (m_valid) seen++;
    end
  endtask

  task automatic sync_tick();
    do cycle(); while (!m_valid);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (3) begin @(posedge clock); #1; check_outputs(); end
    reset_l = 1'b1;
    repeat (5) cycle();

    // Attack -> decay -> sustain on voice 0
    attack = 7'd100; decay = 7'd10; sustain = 7'd50; release_rate = 7'd127;
    gate[0] = 1'b1;
    run_ticks(655);  chk("atk tick655", 32'(level[0]), 32'd65500);
    run_ticks(1);    chk("atk tick656", 32'(level[0]), 32'd65535);
    run_ticks(3278); chk("dec near end", 32'(level[0]), 32'd32755);
    run_ticks(1);    chk("dec clamp S", 32'(level[0]), 32'd32750);
    run_ticks(2);    chk("sustain hold", 32'(level[0]), 32'd32750);

    // Release from sustain
    gate[0] = 1'b0;
    run_ticks(1);    chk("rel entry hold", 32'(level[0]), 32'd32750);
    run_ticks(257);  chk("rel tick258", 32'(level[0]), 32'd111);
    chk("rel still active", 32'(active[0]), 32'd1);
    run_ticks(1);    chk("rel end level", 32'(level[0]), 32'd0);
    chk("rel end idle", 32'(active[0]), 32'd0);

    // Instant stages on voice 1
    attack = 7'd0; decay = 7'd0; sustain = 7'd100;
    gate[1] = 1'b1;
    run_ticks(1);    chk("instant tick1", 32'(level[1]), 32'd65535);
    run_ticks(3);    chk("instant sustain", 32'(level[1]), 32'd65535);

    // Short note entirely between ticks on voice 2
    attack = 7'd100; release_rate = 7'd127;
    sync_tick();
    gate[2] = 1'b1;
    repeat (3) cycle();
    gate[2] = 1'b0;
    run_ticks(1);    chk("short attack", 32'(level[2]), 32'd100);
    chk("short active", 32'(active[2]), 32'd1);
    run_ticks(1);    chk("short release", 32'(level[2]), 32'd100);
    run_ticks(1);    chk("short idle", 32'(active[2]), 32'd0);

    // Rising edge coincident with a tick
    sync_tick();
    repeat (DIV - 1) cycle();
    gate[2] = 1'b1;
    cycle();         chk("edge on tick", 32'(level[2]), 32'd100);
    gate[2] = 1'b0;
    run_ticks(2);    chk("edge on tick idle", 32'(active[2]), 32'd0);

    // Retrigger during release on voice 3 (legato)
    gate[3] = 1'b1;
    run_ticks(200);  chk("v3 attack 20000", 32'(level[3]), 32'd20000);
    gate[3] = 1'b0;
    run_ticks(1);    chk("v3 release hold", 32'(level[3]), 32'd20000);
    gate[3] = 1'b1;
    run_ticks(1);    chk("v3 legato", 32'(level[3]), 32'd20100);
    chk("v1 unaffected", 32'(level[1]), 32'd65535);

    // Randomized rates, sustain (including >100) and gates
    for (int i = 0; i < 60; i++) begin
      attack       = 7'($urandom_range(0, 127));
      decay        = 7'($urandom_range(0, 127));
      release_rate = 7'($urandom_range(0, 127));
      sustain      = 7'($urandom_range(0, 127));
      gate         = VC'($urandom);
      repeat ($urandom_range(1, 40)) cycle();
    end

    // Asynchronous reset mid-attack with gate held through reset
    gate = '0; release_rate = 7'd0;
    run_ticks(3);
    attack = 7'd100;
    gate[0] = 1'b1;
    run_ticks(5);    chk("pre-reset attack", 32'(level[0]), 32'd500);
    #2 reset_l = 1'b0;
    #1;
    chk("async rst level", 32'(level[0]), 32'd0);
    chk("async rst active", 32'(active), 32'd0);
    chk("async rst valid", 32'(level_valid), 32'd0);
    model_reset();
    repeat (2) cycle();
    reset_l = 1'b1;
    run_ticks(3);    chk("held gate no attack", 32'(active[0]), 32'd0);
    gate[0] = 1'b0;
    cycle();
    gate[0] = 1'b1;
    run_ticks(1);    chk("re-rise attack", 32'(level[0]), 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
